alu_muldiv: RTL

- Parametrised next-generation execute-stage unit for the MIPS pipeline.
- Combines a widened combinational ALU, with overflow detection, shifts and compares, with a sequential multiply/divide unit that owns the HI/LO registers.
- The multiply/divide unit uses a start/busy handshake so the hazard unit can stall MFHI/MFLO and further mult/div ops.
- Sits in the E stage; Result feeds the E/M pipeline register, and hi_out/lo_out feed the MFHI/MFLO forwarding mux.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 rtl/alu_muldiv.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the E-stage ALU and the multiply/divide unit.
//   - ALU_* : 4-bit ALUOp encodings decoded by alu_muldiv
//   - MD_*  : 3-bit md_op encodings decoded by muldiv_unit
//   - DEFAULT_WIDTH : default datapath width
//   - md_is_long : true for the ops that occupy the unit for several cycles
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SUBU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  // Multi-cycle ops (everything that raises busy)
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential multiply/divide unit owning the HI/LO registers.
// The arithmetic is done in one step when the request is accepted and held in
// a pending register; a down-counter then models the architectural latency.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   a, b            : operands (rs, rt), sampled with start
//   md_op, start    : operation and one-cycle request pulse
//   busy            : multi-cycle operation in progress (registered)
//   hi, lo          : HI/LO registers (registered)
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [WIDTH-1:0]   hi_r, lo_r, pend_hi_r, pend_lo_r;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               sgn_s;
  logic [2*WIDTH-1:0] mul_a_s, mul_b_s, prod_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quot_s, rem_s;
  logic               neg_a_s, neg_b_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  // Compute the full mult/div result of the operands currently on a/b
  always_comb begin
    sgn_s   = (md_op == MD_MULT) || (md_op == MD_DIV);
    // Sign- or zero-extend to 2*WIDTH so one unsigned multiplier serves both
    mul_a_s = {{WIDTH{sgn_s & a[WIDTH-1]}}, a};
    mul_b_s = {{WIDTH{sgn_s & b[WIDTH-1]}}, b};
    prod_s  = mul_a_s * mul_b_s;
    // Signed divide works on magnitudes; most-negative magnitude fits unsigned
    neg_a_s = sgn_s & a[WIDTH-1];
    neg_b_s = sgn_s & b[WIDTH-1];
    mag_a_s = neg_a_s ? -a : a;
    mag_b_s = neg_b_s ? -b : b;
    if (b == {WIDTH{1'b0}}) begin
      quot_s = {WIDTH{1'b0}};
      rem_s  = {WIDTH{1'b0}};
    end else begin
      quot_s = mag_a_s / mag_b_s;
      rem_s  = mag_a_s % mag_b_s;
    end
    res_hi_s = {WIDTH{1'b0}};
    res_lo_s = {WIDTH{1'b0}};
    case (md_op)
      MD_MULT, MD_MULTU: begin
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b == {WIDTH{1'b0}}) begin
          res_hi_s = a;
          res_lo_s = {WIDTH{1'b1}};
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend.
          // MIN / -1 falls out as quotient MIN, remainder 0.
          res_lo_s = (neg_a_s ^ neg_b_s) ? -quot_s : quot_s;
          res_hi_s = neg_a_s ? -rem_s : rem_s;
        end
      end
      default: begin
        res_hi_s = {WIDTH{1'b0}};
        res_lo_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Request acceptance, latency countdown and HI/LO update
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r    <= 1'b0;
      cnt_r     <= CNT_ZERO;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      pend_hi_r <= {WIDTH{1'b0}};
      pend_lo_r <= {WIDTH{1'b0}};
    end else if (busy_r) begin
      // Requests arriving while busy are dropped on purpose
      if (cnt_r == CNT_ONE) begin
        hi_r   <= pend_hi_r;
        lo_r   <= pend_lo_r;
        busy_r <= 1'b0;
        cnt_r  <= CNT_ZERO;
      end else begin
        cnt_r  <= cnt_r - CNT_ONE;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          pend_hi_r <= res_hi_s;
          pend_lo_r <= res_lo_s;
          cnt_r     <= MULT_LOAD;
          busy_r    <= md_is_long(md_op);
        end
        MD_DIV, MD_DIVU: begin
          pend_hi_r <= res_hi_s;
          pend_lo_r <= res_lo_s;
          cnt_r     <= DIV_LOAD;
          busy_r    <= md_is_long(md_op);
        end
        MD_MTHI: hi_r <= a;
        MD_MTLO: lo_r <= a;
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS E-stage execute unit.
// Combinational ALU (logic, add/sub with signed overflow, compares, shifts,
// LUI) plus a sequential multiply/divide unit holding HI/LO.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   A, B                  : operands (rs, rt/imm)
//   ALUOp, shift_offset   : ALU operation and shift amount
//   Result, Zero, Overflow: combinational ALU outputs
//   md_op, start, busy    : mult/div request and handshake
//   hi_out, lo_out        : HI/LO registers for MFHI/MFLO forwarding
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int SHW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic [SHW-1:0]   shift_offset,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH-1:0] sum_s, diff_s;
  logic             add_ovf_s, sub_ovf_s, slt_s, sltu_s;

  // Shared adder/subtractor and compare terms
  always_comb begin
    sum_s     = A + B;
    diff_s    = A - B;
    // Same-sign add / opposite-sign subtract whose result sign flips
    add_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
    sub_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
    slt_s     = $signed(A) < $signed(B);
    sltu_s    = A < B;
  end

  // ALU operation select
  always_comb begin
    Result   = {WIDTH{1'b0}};
    Overflow = 1'b0;
    case (ALUOp)
      ALU_AND:  Result = A & B;
      ALU_OR:   Result = A | B;
      ALU_ADDU: Result = sum_s;
      ALU_ADD: begin
        Result   = sum_s;
        Overflow = add_ovf_s;
      end
      ALU_XOR:  Result = A ^ B;
      ALU_NOR:  Result = ~(A | B);
      ALU_SUB: begin
        Result   = diff_s;
        Overflow = sub_ovf_s;
      end
      ALU_SUBU: Result = diff_s;
      ALU_SLT:  Result = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_SLTU: Result = {{(WIDTH-1){1'b0}}, sltu_s};
      ALU_SLL:  Result = B << shift_offset;
      ALU_SRL:  Result = B >> shift_offset;
      ALU_SRA:  Result = $signed(B) >>> shift_offset;
      ALU_LUI:  Result = B << (WIDTH / 2);
      default: begin
        Result   = {WIDTH{1'b0}};
        Overflow = 1'b0;
      end
    endcase
  end

  assign Zero = (A == B);

  muldiv_unit #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .a     (A),
    .b     (B),
    .md_op (md_op),
    .start (start),
    .busy  (busy),
    .hi    (hi_out),
    .lo    (lo_out)
  );

endmodule
